// File: rtl/rect_fill_writer.sv
// Rectangle fill engine for a double-buffered 3-3-3 framebuffer.
// Writes one clipped pixel per cycle and swaps buffers only on an idle vblank.
module rect_fill_writer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  x0,
    input  logic [8:0]  y0,
    input  logic [9:0]  largura,
    input  logic [8:0]  altura,
    input  logic [8:0]  cor,
    input  logic        swap_req,
    input  logic        vblank,
    output logic [18:0] endereco,
    output logic [8:0]  data_out,
    output logic        we,
    output logic        buffer_select,
    output logic        busy,
    output logic        done,
    output logic        swap_ack
);

    typedef enum logic [1:0] {IDLE, FILL, FINISH} state_t;

    state_t      state_q, state_d;
    logic [9:0]  x0_q, x0_d;
    logic [9:0]  w_q, w_d;
    logic [8:0]  h_q, h_d;
    logic [9:0]  col_q, col_d;
    logic [8:0]  row_q, row_d;
    logic [18:0] base_q, base_d;
    logic [18:0] addr_q, addr_d;
    logic [8:0]  data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        bsel_q, bsel_d;
    logic        ack_q, ack_d;
    logic        pend_q, pend_d;

    logic [31:0] w_room, h_room;
    logic [9:0]  w_eff;
    logic [8:0]  h_eff;
    logic        degen;
    logic        swap_fire;

    // Start-of-rectangle line base as shift-and-add over the constant H_RES.
    function automatic logic [18:0] line_base(input logic [8:0] y);
        logic [18:0] acc;
        acc = '0;
        for (int i = 0; i < 19; i++) begin
            if (((H_RES >> i) & 1) == 1) begin
                acc = acc + (19'(y) << i);
            end
        end
        return acc;
    endfunction

    assign w_room = 32'(H_RES) - 32'(x0);
    assign h_room = 32'(V_RES) - 32'(y0);
    assign w_eff  = (32'(largura) < w_room) ? largura : w_room[9:0];
    assign h_eff  = (32'(altura) < h_room) ? altura : h_room[8:0];
    assign degen  = (32'(x0) >= 32'(H_RES)) || (32'(y0) >= 32'(V_RES))
                  || (largura == 10'd0) || (altura == 9'd0);

    assign swap_fire = vblank && (pend_q || swap_req)
                     && (state_q == IDLE) && !start;

    // Next-state, scan counters, address generation and swap arbitration.
    always_comb begin
        state_d = state_q;
        x0_d    = x0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        base_d  = base_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bsel_d  = bsel_q;
        ack_d   = 1'b0;
        pend_d  = pend_q | swap_req;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (degen) begin
                        state_d = FINISH;
                    end else begin
                        state_d = FILL;
                        x0_d    = x0;
                        w_d     = w_eff;
                        h_d     = h_eff;
                        col_d   = '0;
                        row_d   = '0;
                        base_d  = line_base(y0);
                        addr_d  = line_base(y0) + 19'(x0);
                        data_d  = cor;
                        we_d    = 1'b1;
                    end
                end
            end
            FILL: begin
                we_d = 1'b1;
                if (col_q == w_q - 10'd1) begin
                    if (row_q == h_q - 9'd1) begin
                        state_d = FINISH;
                        we_d    = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        col_d  = '0;
                        row_d  = row_q + 9'd1;
                        base_d = base_q + 19'(H_RES);
                        addr_d = base_q + 19'(H_RES) + 19'(x0_q);
                    end
                end else begin
                    col_d  = col_q + 10'd1;
                    addr_d = addr_q + 19'd1;
                end
            end
            FINISH: begin
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (swap_fire) begin
            bsel_d = ~bsel_q;
            ack_d  = 1'b1;
            pend_d = 1'b0;
        end
    end

    // State and output registers, all cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            base_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bsel_q  <= 1'b0;
            ack_q   <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bsel_q  <= bsel_d;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
        end
    end

    assign endereco      = addr_q;
    assign data_out      = data_q;
    assign we            = we_q;
    assign buffer_select = bsel_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign swap_ack      = ack_q;

endmodule

// File: tb/tb_rect_fill_writer.sv
// Directed bench for rect_fill_writer: fills, clipping, degenerate starts,
// deferred/collapsed buffer swaps and mid-fill reset.
module tb_rect_fill_writer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  largura;
    logic [8:0]  altura;
    logic [8:0]  cor;
    logic        swap_req;
    logic        vblank;
    logic [18:0] endereco;
    logic [8:0]  data_out;
    logic        we;
    logic        buffer_select;
    logic        busy;
    logic        done;
    logic        swap_ack;

    int passed = 0;
    int total  = 0;

    rect_fill_writer #(.H_RES(640), .V_RES(480)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .x0(x0),
        .y0(y0),
        .largura(largura),
        .altura(altura),
        .cor(cor),
        .swap_req(swap_req),
        .vblank(vblank),
        .endereco(endereco),
        .data_out(data_out),
        .we(we),
        .buffer_select(buffer_select),
        .busy(busy),
        .done(done),
        .swap_ack(swap_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic req_fill(input int x, input int y, input int w,
                            input int h, input int c);
        x0      = 10'(x);
        y0      = 9'(y);
        largura = 10'(w);
        altura  = 9'(h);
        cor     = 9'(c);
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 0);
    endtask

    initial begin
        int exp1 [6];
        exp1 = '{1290, 1291, 1292, 1930, 1931, 1932};

        rst_n = 1'b0; start = 1'b0; x0 = '0; y0 = '0;
        largura = '0; altura = '0; cor = '0;
        swap_req = 1'b0; vblank = 1'b0;
        tick();
        tick();
        chk("rst_we", 32'(we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_addr", 32'(endereco), 0);
        chk("rst_bsel", 32'(buffer_select), 0);

        // Basic 3x2 fill, start on the first edge after reset release
        rst_n = 1'b1;
        req_fill(10, 2, 3, 2, 'h1FF);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("f1_we%0d", i), 32'(we), 1);
            chk($sformatf("f1_addr%0d", i), 32'(endereco), 32'(exp1[i]));
            chk($sformatf("f1_data%0d", i), 32'(data_out), 'h1FF);
            chk($sformatf("f1_done%0d", i), 32'(done), 0);
            tick();
        end
        chk("f1_we_end", 32'(we), 0);
        chk("f1_done", 32'(done), 1);
        chk("f1_busy_fin", 32'(busy), 1);
        tick();
        chk("f1_done_low", 32'(done), 0);
        chk("f1_busy_low", 32'(busy), 0);
        chk("f1_data_hold", 32'(data_out), 'h1FF);

        // Clipped at bottom-right corner
        req_fill(638, 479, 5, 4, 'h0AA);
        chk("f2_addr0", 32'(endereco), 307198);
        chk("f2_we0", 32'(we), 1);
        tick();
        chk("f2_addr1", 32'(endereco), 307199);
        chk("f2_we1", 32'(we), 1);
        tick();
        chk("f2_we_end", 32'(we), 0);
        chk("f2_done", 32'(done), 1);
        tick();

        // Zero width: no writes, done two cycles after start
        req_fill(5, 5, 0, 3, 'h011);
        chk("f3_we0", 32'(we), 0);
        chk("f3_busy0", 32'(busy), 1);
        chk("f3_done0", 32'(done), 0);
        tick();
        chk("f3_we1", 32'(we), 0);
        chk("f3_busy1", 32'(busy), 1);
        chk("f3_done1", 32'(done), 1);
        tick();
        chk("f3_busy2", 32'(busy), 0);
        chk("f3_done2", 32'(done), 0);
        chk("f3_data_hold", 32'(data_out), 'h0AA);

        // Swap requested, vblank during fill is deferred
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        req_fill(0, 0, 4, 1, 'h003);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("s1_bsel_fill", 32'(buffer_select), 0);
        chk("s1_ack_fill", 32'(swap_ack), 0);
        chk("s1_addr", 32'(endereco), 1);
        wait_idle();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("s1_bsel", 32'(buffer_select), 1);
        chk("s1_ack", 32'(swap_ack), 1);
        tick();
        chk("s1_ack_low", 32'(swap_ack), 0);

        // vblank together with start is deferred, pending retained
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vblank = 1'b1;
        req_fill(0, 0, 0, 1, 'h003);
        vblank = 1'b0;
        chk("s2_bsel_start", 32'(buffer_select), 1);
        chk("s2_ack_start", 32'(swap_ack), 0);
        wait_idle();
        // Extra requests collapse into the one pending swap
        swap_req = 1'b1;
        tick();
        tick();
        swap_req = 1'b0;
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("s2_bsel", 32'(buffer_select), 0);
        chk("s2_ack", 32'(swap_ack), 1);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("s2_bsel_once", 32'(buffer_select), 0);
        chk("s2_ack_once", 32'(swap_ack), 0);

        // swap_req and vblank in the same idle cycle
        swap_req = 1'b1;
        vblank = 1'b1;
        tick();
        swap_req = 1'b0;
        vblank = 1'b0;
        chk("s3_bsel", 32'(buffer_select), 1);
        chk("s3_ack", 32'(swap_ack), 1);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        chk("s3_bsel_hold", 32'(buffer_select), 1);
        chk("s3_ack_low", 32'(swap_ack), 0);

        // Reset in the middle of a 10x10 fill
        req_fill(100, 10, 10, 10, 'h123);
        for (int i = 0; i < 5; i++) tick();
        chk("r_we_mid", 32'(we), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_we", 32'(we), 0);
        chk("r_busy", 32'(busy), 0);
        chk("r_addr", 32'(endereco), 0);
        chk("r_data", 32'(data_out), 0);
        chk("r_bsel", 32'(buffer_select), 0);
        chk("r_done", 32'(done), 0);
        chk("r_ack", 32'(swap_ack), 0);
        tick();
        tick();
        chk("r_we_hold", 32'(we), 0);
        chk("r_done_hold", 32'(done), 0);
        rst_n = 1'b1;
        req_fill(0, 1, 2, 1, 'h055);
        chk("r2_addr0", 32'(endereco), 640);
        chk("r2_data0", 32'(data_out), 'h055);
        chk("r2_we0", 32'(we), 1);
        tick();
        chk("r2_addr1", 32'(endereco), 641);
        tick();
        chk("r2_we_end", 32'(we), 0);
        chk("r2_done", 32'(done), 1);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
